// File: rtl/hex_scan_driver.sv
// hex_scan_driver
//   Time-multiplexed scan driver for a 4-digit common-anode 7-segment display.
//   A 16-bit hex value, per-digit point bits and per-digit blank bits are
//   captured into shadow registers on `load`. A free-running prescaler advances
//   the active digit every 2^DIV_BITS clocks. For each digit the driver presents
//   one nibble plus its point and blank (LE) bits to an MC14495-style decoder,
//   and drives the matching active-low anode.
//
//   Parameters:
//     DIV_BITS  prescaler width (>= 1); each digit dwells 2^DIV_BITS clocks
//
//   Ports:
//     clk     system clock, rising edge
//     rst     asynchronous active-high reset
//     load    one-cycle strobe capturing num/points/les
//     num     hex value, digit i = num[4i+3:4i]
//     points  per-digit point bits
//     les     per-digit blank bits (1 = blank)
//     hex     nibble of the active digit (decoder D3..D0)
//     point   point bit of the active digit
//     le      blank bit of the active digit (decoder LE)
//     an      anode selects, active-low, one-hot
//     frame   one-cycle pulse after the scan wraps from digit 3 to digit 0
//
//   Build option:
//     HEX_SCAN_LZB_EN  when defined, digits 1..3 are also blanked when they and
//                      every more-significant nibble are zero (leading-zero
//                      blanking). Digit 0 is never auto-blanked.

module hex_scan_driver #(
  parameter int unsigned DIV_BITS = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] num,
  input  logic [3:0]  points,
  input  logic [3:0]  les,
  output logic [3:0]  hex,
  output logic        point,
  output logic        le,
  output logic [3:0]  an,
  output logic        frame
);

  localparam logic [DIV_BITS-1:0] CNT_ONE = DIV_BITS'(1);

  logic [DIV_BITS-1:0] r_cnt;
  logic [1:0]          r_idx;
  logic [15:0]         r_num;
  logic [3:0]          r_pts;
  logic [3:0]          r_les;
  logic                r_frame;
  logic                w_adv;

  // Digit advances on the last clock of each dwell period.
  assign w_adv = &r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_frame <= 1'b0;
    end else begin
      r_cnt   <= r_cnt + CNT_ONE;
      if (w_adv) begin
        r_idx <= r_idx + 2'd1;
      end
      // Registered so the pulse lines up with the first cycle of digit 0.
      r_frame <= w_adv && (r_idx == 2'd3);
    end
  end

  // Shadow registers are independent of the scan phase, so a load never
  // perturbs the dwell timing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_num <= '0;
      r_pts <= '1;
      r_les <= '0;
    end else if (load) begin
      r_num <= num;
      r_pts <= points;
      r_les <= les;
    end
  end

`ifdef HEX_SCAN_LZB_EN
  logic [3:0] w_lzb;

  // Bit i set when nibbles i..3 are all zero; digit 0 always shows.
  assign w_lzb = {(r_num[15:12] == 4'h0),
                  (r_num[15:8]  == 8'h00),
                  (r_num[15:4]  == 12'h000),
                  1'b0};
`endif

  always_comb begin
    an    = ~(4'b0001 << r_idx);
    hex   = r_num[3:0];
    point = r_pts[r_idx];
    case (r_idx)
      2'd0:    hex = r_num[3:0];
      2'd1:    hex = r_num[7:4];
      2'd2:    hex = r_num[11:8];
      default: hex = r_num[15:12];
    endcase
`ifdef HEX_SCAN_LZB_EN
    le = r_les[r_idx] | w_lzb[r_idx];
`else
    le = r_les[r_idx];
`endif
  end

  assign frame = r_frame;

endmodule

// File: tb/tb_hex_scan_driver.sv
// Bench for hex_scan_driver with DIV_BITS = 2 (4-clock dwell, 16-clock frame).
// The stimulus process pushes the expected outputs for each cycle into a queue;
// a monitor pops and compares on the falling edge.

module tb_hex_scan_driver;

  localparam int unsigned DIV_BITS = 2;

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] num;
  logic [3:0]  points;
  logic [3:0]  les;
  logic [3:0]  hex;
  logic        point;
  logic        le;
  logic [3:0]  an;
  logic        frame;

  hex_scan_driver #(.DIV_BITS(DIV_BITS)) dut (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .num    (num),
    .points (points),
    .les    (les),
    .hex    (hex),
    .point  (point),
    .le     (le),
    .an     (an),
    .frame  (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [3:0] hex;
    logic       point;
    logic       le;
    logic       frame;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference state, in spec terms: shadow contents and edges since reset release.
  logic        in_rst;
  int          ph;
  logic [15:0] e_num;
  logic [3:0]  e_pts;
  logic [3:0]  e_les;

  function automatic exp_t expect_now(input string tag);
    exp_t e;
    int   d;
    e.tag = tag;
    if (in_rst) begin
      e.an = 4'b1110; e.hex = 4'h0; e.point = 1'b1; e.le = 1'b0; e.frame = 1'b0;
    end else begin
      d       = (ph / 4) % 4;
      e.an    = 4'b1111;
      e.an[d] = 1'b0;
      e.hex   = 4'((e_num >> (4 * d)) & 16'h000F);
      e.point = e_pts[d];
      e.le    = e_les[d];
`ifdef HEX_SCAN_LZB_EN
      if (d != 0 && (e_num >> (4 * d)) == 16'h0000) e.le = 1'b1;
`endif
      e.frame = (ph > 0) && (ph % 16 == 0);
    end
    return e;
  endfunction

  task automatic model_reset();
    in_rst = 1'b1;
    e_num  = 16'h0000;
    e_pts  = 4'b1111;
    e_les  = 4'b0000;
  endtask

  // Advance one clock with the currently driven inputs, then queue the expectation.
  task automatic edge_step(input string tag);
    @(posedge clk);
    if (!in_rst) begin
      if (load) begin
        e_num = num; e_pts = points; e_les = les;
      end
      ph = ph + 1;
    end
    #1;
    exp_q.push_back(expect_now(tag));
  endtask

  task automatic release_rst();
    rst    = 1'b0;
    in_rst = 1'b0;
    ph     = 0;
  endtask

  task automatic do_load(input logic [15:0] n, input logic [3:0] p, input logic [3:0] l,
                         input string tag);
    num = n; points = p; les = l; load = 1'b1;
    edge_step(tag);
    load = 1'b0;
  endtask

  task automatic chk(input string tag, input string fld, input logic [3:0] got,
                     input logic [3:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s.%s got=%b expected=%b @%0t", tag, fld, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.tag, "an",    an,            e.an);
      chk(e.tag, "hex",   hex,           e.hex);
      chk(e.tag, "point", {3'b0, point}, {3'b0, e.point});
      chk(e.tag, "le",    {3'b0, le},    {3'b0, e.le});
      chk(e.tag, "frame", {3'b0, frame}, {3'b0, e.frame});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired got=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int wait_cyc;
    rst = 1'b1; load = 1'b0; num = 16'h0000; points = 4'b0000; les = 4'b0000;
    ph = 0;
    model_reset();

    // Held reset: outputs constant at reset values.
    repeat (10) edge_step("reset");
    release_rst();

    // Load 1A3F, then scan 2.5 frames while num wiggles with load low.
    do_load(16'h1A3F, 4'b1011, 4'b0000, "load1a3f");
    for (int i = 0; i < 40; i++) begin
      num = 16'($urandom);
      points = 4'($urandom);
      les = 4'($urandom);
      edge_step("scan1a3f");
    end

    // Load 0000 mid-digit, then FFFF on the digit-advance edge (ph becomes 44).
    do_load(16'h0000, 4'b0000, 4'b0000, "load0000");
    num = 16'hFFFF;
    edge_step("noload");
    do_load(16'hFFFF, 4'b0000, 4'b0000, "loadadv");
    repeat (13) edge_step("scanffff");

    // Asynchronous reset in the middle of digit 2: visible before the next edge.
    @(posedge clk);
    ph = ph + 1;
    #2;
    rst = 1'b1;
    model_reset();
    exp_q.push_back(expect_now("async_rst"));
    repeat (2) edge_step("in_rst");
    release_rst();
    repeat (20) edge_step("post_rst");

    // Leading-zero blanking vectors and plain per-digit blanks.
    do_load(16'h0050, 4'b0000, 4'b0000, "lzb0050");
    repeat (16) edge_step("lzb0050");
    do_load(16'h0000, 4'b0000, 4'b0000, "lzb0000");
    repeat (16) edge_step("lzb0000");
    do_load(16'h1A3F, 4'b0101, 4'b1010, "les1010");
    repeat (16) edge_step("les1010");

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain got=%0d pending expected=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hex_scan_driver.md
# hex_scan_driver

Time-multiplexed scan driver for a 4-digit common-anode 7-segment display. It latches a 16-bit hex value with per-digit point and blank bits, then cycles through the digits at a divided rate. For each digit it presents one nibble, plus its point and blank (LE) bits, to the downstream MC14495-style hex-to-segment decoder, and drives the matching active-low anode. It sits between the datapath or register file and the segment decoder on the board display path.

## Interface
- `DIV_BITS`, default 17: width of the scan prescaler; the digit advances every 2^DIV_BITS clocks.
- `clk` input 1: system clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `load` input 1: one-cycle strobe; captures `num`, `points` and `les` into the shadow registers.
- `num` input 16: hex value; digit i is `num[4i+3:4i]`.
- `points` input 4: per-digit point bit, passed unchanged to the decoder `point` input.
- `les` input 4: per-digit blank bit; 1 blanks that digit (decoder LE).
- `hex` output 4: nibble of the active digit, wired to D3..D0.
- `point` output 1: point bit of the active digit.
- `le` output 1: blank bit of the active digit.
- `an` output 4: anode selects, active-low, exactly one bit low.
- `frame` output 1: one-cycle pulse when the scan wraps from digit 3 to digit 0.

## Operation
- Shadow registers `num_q[15:0]`, `pts_q[3:0]` and `les_q[3:0]` load on any clock edge with `load`=1. With `load`=0 they hold.
- The prescaler `cnt[DIV_BITS-1:0]` increments every clock and wraps from all-ones to 0.
- The digit index `idx[1:0]` increments when `cnt` is all-ones. It wraps 3 -> 0.
- Outputs are decoded combinationally from `idx` and the shadow registers:
  - `an = ~(4'b0001 << idx)`
  - `hex = num_q[4*idx +: 4]`
  - `point = pts_q[idx]`
  - `le = les_q[idx]`, or the leading-zero blank when that feature is enabled (see Configuration).
- `frame` is a registered output. It goes to 1 for exactly the one clock after the edge where `idx` goes 3 -> 0, otherwise it is 0.
- Reset values: `cnt`=0, `idx`=0, `num_q`=0, `pts_q`=4'b1111, `les_q`=4'b0000, `frame`=0.
  - Resulting output values: `an`=4'b1110, `hex`=0, `point`=1, `le`=0.

## Timing
- Load latency: the new shadow value is visible on `hex`/`point`/`le` in the cycle after the `load` edge, for whichever digit is active.
- A load never disturbs `cnt` or `idx`; the scan phase is continuous.
- Each digit stays active for exactly 2^DIV_BITS clocks. A full frame is 4·2^DIV_BITS clocks.
- When `load` coincides with a digit advance, both take effect on the same edge. The newly selected digit shows the newly loaded data.
- Reset asserted mid-frame:
  - all registers go to their reset values immediately (asynchronously);
  - scanning restarts at digit 0 with a full-length dwell after `rst` falls;
  - no `frame` pulse is produced by the reset.
- `DIV_BITS` must be at least 1. `DIV_BITS`=1 advances the digit every 2 clocks.

## Configuration
- Macro: `HEX_SCAN_LZB_EN`.
- Defined: leading-zero blanking is enabled.
  - Digit i (i = 1..3) is forced to `le`=1 when `num_q` nibbles i..3 are all zero.
  - Digit 0 is never auto-blanked.
  - The final value is `le = les_q[idx] | lzb[idx]`.
- Undefined: `le = les_q[idx]` only, with no added logic.

## Test plan
- Reset with `DIV_BITS`=2 -> `an`=1110, `hex`=0, `point`=1, `le`=0, `frame`=0. Hold `rst` for 10 clocks -> outputs stay constant.
- `load` with `num`=16'h1A3F, `points`=4'b1011, `les`=0, `DIV_BITS`=2 -> `hex` sequence F,3,A,1 with `an` 1110,1101,1011,0111. Each digit lasts 4 clocks. `point` sequence 1,1,0,1.
- Continue the previous run -> `frame` is high for exactly 1 clock every 16 clocks, in the cycle after `idx` returns to 0.
- `load` on the same edge as a digit advance, changing `num` from 16'h0000 to 16'hFFFF -> the new digit shows `hex`=F immediately. `num` changes with `load`=0 -> no effect.
- Assert `rst` in the middle of digit 2 -> `an`=1110 at once. After release, digit 0 dwells a full 4 clocks.
- With `HEX_SCAN_LZB_EN`, `num`=16'h0050 -> `le` sequence 0,0,1,1 for digits 0..3. `num`=16'h0000 -> `le` sequence 0,1,1,1. Without the macro -> all 0.
